// File: rtl/rob_commit_pkg.sv
// Shared CPU parameters and the reorder-buffer entry record used by the
// commit logic.
package rob_commit_pkg;

  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned PREG_WIDTH = 6;
  localparam int unsigned AREG_W     = 5;

  // Payload of one ROB entry in the default configuration.
  typedef struct packed {
    logic                  has_dest;
    logic [AREG_W-1:0]     dr;
    logic [PREG_WIDTH-1:0] pdr;
    logic [PREG_WIDTH-1:0] old_pdr;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit.sv
// In-order commit reorder buffer: allocates at the tail, marks completions,
// retires one done entry per cycle from the head and frees old mappings.
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int unsigned DEPTH  = ROB_DEPTH,
  parameter int unsigned PREG_W = PREG_WIDTH,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned PTR_W = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_has_dest,
  input  logic [AREG_W-1:0] alloc_dr,
  input  logic [PREG_W-1:0] alloc_pdr,
  input  logic [PREG_W-1:0] alloc_old_pdr,
  output logic [IDX_W-1:0]  alloc_rob_num,
  input  logic              cmpl_valid,
  input  logic [IDX_W-1:0]  cmpl_rob_num,
  output logic              retire_valid,
  output logic [AREG_W-1:0] retire_dr,
  output logic [PREG_W-1:0] retire_pdr,
  output logic              free_valid,
  output logic [PREG_W-1:0] free_preg,
  output logic [PTR_W-1:0]  count,
  output logic              cmpl_err
);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic              cmpl_err_q, cmpl_err_d;

  logic              has_dest_q [DEPTH];
  logic [AREG_W-1:0] dr_q       [DEPTH];
  logic [PREG_W-1:0] pdr_q      [DEPTH];
  logic [PREG_W-1:0] old_pdr_q  [DEPTH];

  logic              retire_valid_q, retire_valid_d;
  logic [AREG_W-1:0] retire_dr_q, retire_dr_d;
  logic [PREG_W-1:0] retire_pdr_q, retire_pdr_d;
  logic              free_valid_q, free_valid_d;
  logic [PREG_W-1:0] free_preg_q, free_preg_d;

  logic [IDX_W-1:0]  head_idx;
  logic [IDX_W-1:0]  tail_idx;
  logic              alloc_fire;
  logic              commit_fire;

  assign head_idx    = head_q[IDX_W-1:0];
  assign tail_idx    = tail_q[IDX_W-1:0];
  // Readiness looks only at registered occupancy, so a same-cycle commit
  // never opens a slot for a full buffer.
  assign alloc_ready = (count_q < PTR_W'(DEPTH));
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign commit_fire = valid_q[head_idx] && done_q[head_idx];

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    valid_d    = valid_q;
    done_d     = done_q;
    cmpl_err_d = cmpl_err_q;

    if (cmpl_valid) begin
      if (valid_q[cmpl_rob_num]) begin
        done_d[cmpl_rob_num] = 1'b1;
      end else begin
        cmpl_err_d = 1'b1;
      end
    end

    if (commit_fire) begin
      valid_d[head_idx] = 1'b0;
      head_d            = head_q + PTR_W'(1);
    end

    if (alloc_fire) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
      tail_d            = tail_q + PTR_W'(1);
    end

    case ({alloc_fire, commit_fire})
      2'b10:   count_d = count_q + PTR_W'(1);
      2'b01:   count_d = count_q - PTR_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    retire_valid_d = commit_fire;
    retire_dr_d    = retire_dr_q;
    retire_pdr_d   = retire_pdr_q;
    free_valid_d   = 1'b0;
    free_preg_d    = '0;
    if (commit_fire) begin
      retire_dr_d  = dr_q[head_idx];
      retire_pdr_d = pdr_q[head_idx];
      // Physical register 0 is never handed back to the free list.
      if (has_dest_q[head_idx] && (old_pdr_q[head_idx] != '0)) begin
        free_valid_d = 1'b1;
        free_preg_d  = old_pdr_q[head_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      done_q         <= '0;
      cmpl_err_q     <= 1'b0;
      retire_valid_q <= 1'b0;
      retire_dr_q    <= '0;
      retire_pdr_q   <= '0;
      free_valid_q   <= 1'b0;
      free_preg_q    <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      done_q         <= done_d;
      cmpl_err_q     <= cmpl_err_d;
      retire_valid_q <= retire_valid_d;
      retire_dr_q    <= retire_dr_d;
      retire_pdr_q   <= retire_pdr_d;
      free_valid_q   <= free_valid_d;
      free_preg_q    <= free_preg_d;
    end
  end

  // Payload needs no reset: it is only read behind a set valid bit.
  always_ff @(posedge clk) begin
    if (!rst && alloc_fire) begin
      has_dest_q[tail_idx] <= alloc_has_dest;
      dr_q[tail_idx]       <= alloc_dr;
      pdr_q[tail_idx]      <= alloc_pdr;
      old_pdr_q[tail_idx]  <= alloc_old_pdr;
    end
  end

  assign alloc_rob_num = tail_idx;
  assign count         = count_q;
  assign cmpl_err      = cmpl_err_q;
  assign retire_valid  = retire_valid_q;
  assign retire_dr     = retire_dr_q;
  assign retire_pdr    = retire_pdr_q;
  assign free_valid    = free_valid_q;
  assign free_preg     = free_preg_q;

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed scenarios followed by random
// traffic, compared each cycle against a queue-based reference model.
module tb_rob_commit;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid;
  logic       alloc_ready;
  logic       alloc_has_dest;
  logic [4:0] alloc_dr;
  logic [5:0] alloc_pdr;
  logic [5:0] alloc_old_pdr;
  logic [3:0] alloc_rob_num;
  logic       cmpl_valid;
  logic [3:0] cmpl_rob_num;
  logic       retire_valid;
  logic [4:0] retire_dr;
  logic [5:0] retire_pdr;
  logic       free_valid;
  logic [5:0] free_preg;
  logic [4:0] count;
  logic       cmpl_err;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_has_dest (alloc_has_dest),
    .alloc_dr       (alloc_dr),
    .alloc_pdr      (alloc_pdr),
    .alloc_old_pdr  (alloc_old_pdr),
    .alloc_rob_num  (alloc_rob_num),
    .cmpl_valid     (cmpl_valid),
    .cmpl_rob_num   (cmpl_rob_num),
    .retire_valid   (retire_valid),
    .retire_dr      (retire_dr),
    .retire_pdr     (retire_pdr),
    .free_valid     (free_valid),
    .free_preg      (free_preg),
    .count          (count),
    .cmpl_err       (cmpl_err)
  );

  // Reference model: in-flight instructions oldest first.
  typedef struct {
    int idx;
    int dr;
    int pdr;
    int old;
    bit hd;
    bit done;
  } ent_t;

  ent_t q[$];
  int   tail_m;
  bit   err_m, rv_m, fv_m;
  int   rdr_m, rpdr_m, fp_m;
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit av, input bit hd, input int dr, input int pdr,
                            input int old, input bit cv, input int cn, input bit r);
    bit   ready, com, found;
    ent_t c, n;
    if (r) begin
      q.delete();
      tail_m = 0;
      err_m  = 0;
      rv_m   = 0;
      fv_m   = 0;
      return;
    end
    ready = (q.size() < DEPTH);
    com   = (q.size() > 0) && q[0].done;
    if (cv) begin
      found = 0;
      foreach (q[i]) if (q[i].idx == cn) begin q[i].done = 1; found = 1; end
      if (!found) err_m = 1;
    end
    rv_m = 0;
    fv_m = 0;
    if (com) begin
      c      = q.pop_front();
      rv_m   = 1;
      rdr_m  = c.dr;
      rpdr_m = c.pdr;
      fv_m   = c.hd && (c.old != 0);
      fp_m   = c.old;
    end
    if (av && ready) begin
      n = '{idx: tail_m, dr: dr, pdr: pdr, old: old, hd: hd, done: 0};
      q.push_back(n);
      tail_m = (tail_m + 1) % DEPTH;
    end
  endtask

  task automatic cyc(input bit av, input bit hd, input int dr, input int pdr, input int old,
                     input bit cv, input int cn, input bit r);
    alloc_valid    = av;
    alloc_has_dest = hd;
    alloc_dr       = 5'(dr);
    alloc_pdr      = 6'(pdr);
    alloc_old_pdr  = 6'(old);
    cmpl_valid     = cv;
    cmpl_rob_num   = 4'(cn);
    rst            = r;
    @(posedge clk);
    model_step(av, hd, dr, pdr, old, cv, cn, r);
    #1;
    chk("alloc_ready", alloc_ready, q.size() < DEPTH);
    chk("count", count, q.size());
    chk("alloc_rob_num", alloc_rob_num, tail_m);
    chk("retire_valid", retire_valid, rv_m);
    chk("free_valid", free_valid, fv_m);
    chk("cmpl_err", cmpl_err, err_m);
    if (rv_m) begin
      chk("retire_dr", retire_dr, rdr_m);
      chk("retire_pdr", retire_pdr, rpdr_m);
    end
    if (fv_m) chk("free_preg", free_preg, fp_m);
    if (r) begin
      chk("rst_retire_dr", retire_dr, 0);
      chk("rst_retire_pdr", retire_pdr, 0);
      chk("rst_free_preg", free_preg, 0);
    end
  endtask

  task automatic do_alloc(input int dr, input int pdr, input int old, input bit hd);
    cyc(1, hd, dr, pdr, old, 0, 0, 0);
  endtask
  task automatic do_cmpl(input int n);
    cyc(0, 0, 0, 0, 0, 1, n, 0);
  endtask
  task automatic do_idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_rst();
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    bit av, cv, hd, r;
    int cn, old;

    do_rst();
    do_rst();
    chk("reset_count", count, 0);
    chk("reset_ready", alloc_ready, 1);

    // Single instruction round trip.
    chk("t1_rob_num", alloc_rob_num, 0);
    do_alloc(5, 33, 5, 1);
    chk("t1_count", count, 1);
    do_cmpl(0);
    chk("t1_not_yet", retire_valid, 0);
    do_idle();
    chk("t1_retire", retire_valid, 1);
    chk("t1_dr", retire_dr, 5);
    chk("t1_pdr", retire_pdr, 33);
    chk("t1_free", free_valid, 1);
    chk("t1_free_preg", free_preg, 5);
    do_idle();
    chk("t1_one_pulse", retire_valid, 0);

    // Out-of-order completion retires in order.
    do_rst();
    do_alloc(1, 10, 20, 1);
    do_alloc(2, 11, 21, 1);
    do_alloc(3, 12, 22, 1);
    do_cmpl(2);
    do_cmpl(1);
    do_cmpl(0);
    do_idle();
    chk("t2_first", retire_dr, 1);
    do_idle();
    chk("t2_second", retire_dr, 2);
    do_idle();
    chk("t2_third", retire_dr, 3);
    chk("t2_third_valid", retire_valid, 1);
    do_idle();

    // Full buffer and wrap of the tail.
    do_rst();
    for (int i = 0; i < DEPTH; i++) do_alloc(i + 1, i + 30, i + 1, 1);
    chk("t3_full_ready", alloc_ready, 0);
    chk("t3_full_count", count, 16);
    cyc(1, 1, 17, 50, 17, 1, 0, 0);
    chk("t3_not_accepted", count, 16);
    cyc(1, 1, 17, 50, 17, 0, 0, 0);
    chk("t3_after_commit_ready", alloc_ready, 1);
    chk("t3_wrap_rob_num", alloc_rob_num, 0);
    chk("t3_after_commit_count", count, 15);
    cyc(1, 1, 17, 50, 17, 0, 0, 0);
    chk("t3_refill_count", count, 16);

    // No free when no destination or old mapping is p0.
    do_rst();
    do_alloc(7, 40, 9, 0);
    do_alloc(8, 41, 0, 1);
    do_cmpl(0);
    do_cmpl(1);
    chk("t4_nodest_retire", retire_valid, 1);
    chk("t4_nodest_free", free_valid, 0);
    do_idle();
    chk("t4_p0_retire", retire_valid, 1);
    chk("t4_p0_free", free_valid, 0);

    // Completion of an empty entry is sticky until reset.
    do_rst();
    do_cmpl(7);
    chk("t5_err", cmpl_err, 1);
    repeat (3) do_idle();
    chk("t5_err_sticky", cmpl_err, 1);
    chk("t5_no_retire", retire_valid, 0);
    do_rst();
    chk("t5_err_cleared", cmpl_err, 0);

    // Reset with work in flight.
    for (int i = 0; i < 4; i++) do_alloc(i, i + 1, i + 2, 1);
    do_rst();
    chk("t6_count", count, 0);
    chk("t6_ready", alloc_ready, 1);
    do_cmpl(0);
    chk("t6_stale_cmpl_err", cmpl_err, 1);

    // Random traffic against the model.
    do_rst();
    for (int k = 0; k < 3000; k++) begin
      av  = ($urandom_range(99) < 60);
      cv  = ($urandom_range(99) < 50);
      hd  = ($urandom_range(99) < 80);
      old = ($urandom_range(99) < 20) ? 0 : int'($urandom_range(63));
      r   = ($urandom_range(999) < 5);
      if (q.size() > 0 && $urandom_range(99) < 97)
        cn = q[$urandom_range(q.size() - 1)].idx;
      else
        cn = int'($urandom_range(15));
      cyc(av, hd, int'($urandom_range(31)), int'($urandom_range(63)), old, cv, cn, r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
